// File: rtl/list_walker.sv
// list_walker: synchronous RAM with a load port plus a pointer-chasing engine.
// A walk starts at start_addr and follows the next pointer held in the low
// ADDR_WIDTH bits of each word until it reads the null pointer (address 0).
// It then reports the node count and the last node address. A walk that
// reaches MAX_STEPS nodes stops with loop_err set, which catches cyclic lists.
//
// Handshake: start is a request that is accepted only in IDLE. Requests made
// while busy or during the done cycle are dropped, not queued. done is a
// single-cycle completion strobe. length, last_addr and loop_err stay valid
// from done until the next accepted start. There is no backpressure.
module list_walker #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_STEPS  = 2**ADDR_WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] last_addr,
  output logic                  loop_err,
  output logic [1:0]            fsm_state
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] nxt;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic                  at_null;
  logic                  at_limit;

  // Only the pointer field of a word matters to the walker.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^rdata[DATA_WIDTH-1:ADDR_WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the per-node decode of the word just read.
  always_comb begin
    state_nxt = state;
    nxt       = rdata[ADDR_WIDTH-1:0];
    cnt_inc   = {1'b0, cnt} + (ADDR_WIDTH+1)'(1);
    at_null   = (nxt == '0);
    at_limit  = (cnt_inc == (ADDR_WIDTH+1)'(MAX_STEPS));
    case (state)
      S_IDLE:  if (start) state_nxt = (start_addr == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_DATA;
      S_DATA:  state_nxt = (at_null || at_limit) ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // RAM. Loads are accepted only in IDLE, so a walk always sees a stable list.
  // A write in the same cycle as start lands before the first fetch.
  always_ff @(posedge clk) begin
    if (we && state == S_IDLE) mem[waddr] <= wdata;
    if (state == S_FETCH)      rdata <= mem[cur];
  end

  // Walk datapath: current node, node counter and the reported results.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= '0;
      cnt       <= '0;
      length    <= '0;
      last_addr <= '0;
      loop_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            loop_err <= 1'b0;
            if (start_addr == '0) begin
              length    <= '0;
              last_addr <= '0;
            end else begin
              cur <= start_addr;
              cnt <= '0;
            end
          end
        end
        S_DATA: begin
          cnt <= cnt_inc[ADDR_WIDTH-1:0];
          if (at_null) begin
            length    <= cnt_inc[ADDR_WIDTH-1:0];
            last_addr <= cur;
          end else if (at_limit) begin
            length    <= ADDR_WIDTH'(MAX_STEPS);
            last_addr <= cur;
            loop_err  <= 1'b1;
          end else begin
            cur <= nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_FETCH) || (state == S_DATA);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_list_walker.sv
// Testbench for list_walker: directed scenarios followed by random lists,
// checked against a behavioural list-walk model that works on an array copy
// of the memory.
module tb_list_walker;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MS = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          busy;
  logic          done;
  logic [AW-1:0] length;
  logic [AW-1:0] last_addr;
  logic          loop_err;
  logic [1:0]    fsm_state;

  int vectors = 0;
  int fails   = 0;

  logic [DW-1:0] ref_mem [16];

  list_walker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .start(start), .start_addr(start_addr), .busy(busy), .done(done),
    .length(length), .last_addr(last_addr), .loop_err(loop_err),
    .fsm_state(fsm_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load one word; the caller is positioned at a falling edge.
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    ref_mem[a] = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Reference walk: follow pointers in the model array.
  task automatic ref_walk(input logic [AW-1:0] a, output int len, output int last, output int err);
    logic [AW-1:0] cur;
    logic [AW-1:0] nx;
    len = 0; last = 0; err = 0;
    cur = a;
    if (a != 0) begin
      for (int k = 1; k <= MS; k++) begin
        nx = ref_mem[cur][AW-1:0];
        if (nx == 0) begin
          len = k; last = int'(cur);
          break;
        end
        if (k == MS) begin
          len = MS; last = int'(cur); err = 1;
          break;
        end
        cur = nx;
      end
    end
  endtask

  // Start a walk (optionally with a same-cycle load) and check the whole
  // response. When inject >= 0, a write of mem[2]=9 and a start at 5 are
  // driven in that busy cycle and must be ignored.
  task automatic run_walk(input string tag, input logic [AW-1:0] a, input int inject,
                          input bit with_write, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int len, last, err, busy_n;
    bit seen;
    if (with_write) begin
      we = 1'b1; waddr = wa; wdata = wd;
      ref_mem[wa] = wd;
    end
    ref_walk(a, len, last, err);
    start = 1'b1; start_addr = a;
    @(negedge clk);
    start = 1'b0; we = 1'b0;
    busy_n = 0; seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (i == inject) begin
        we = 1'b1; waddr = 4'd2; wdata = 32'd9;
        start = 1'b1; start_addr = 4'd5;
      end
      @(negedge clk);
      we = 1'b0; start = 1'b0;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, busy_n, 2*len);
    chk({tag, "_length"}, 32'(length), len);
    chk({tag, "_last_addr"}, 32'(last_addr), last);
    chk({tag, "_loop_err"}, 32'(loop_err), err);
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
    chk({tag, "_length_held"}, 32'(length), len);
    chk({tag, "_last_held"}, 32'(last_addr), last);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] wd;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; start = 1'b0; start_addr = '0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_length", 32'(length), 32'd0);
    chk("rst_last", 32'(last_addr), 32'd0);
    chk("rst_loop_err", 32'(loop_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Give every word a defined value.
    for (int a = 0; a < 16; a++) write_word(a[AW-1:0], 32'd0);

    // Chain 3 -> 7 -> 2 -> null.
    write_word(4'd3, 32'd7);
    write_word(4'd7, 32'd2);
    write_word(4'd2, 32'd0);
    run_walk("chain", 4'd3, -1, 1'b0, 4'd0, 32'd0);

    // Null start.
    run_walk("null", 4'd0, -1, 1'b0, 4'd0, 32'd0);

    // Two-node cycle caught by the step limit.
    write_word(4'd5, 32'd6);
    write_word(4'd6, 32'd5);
    run_walk("cycle", 4'd5, -1, 1'b0, 4'd0, 32'd0);

    // Write and start during busy are dropped; follow-up walk is unchanged.
    run_walk("busy_ign", 4'd3, 2, 1'b0, 4'd0, 32'd0);
    run_walk("follow", 4'd3, -1, 1'b0, 4'd0, 32'd0);

    // Reset during a DATA cycle.
    start = 1'b1; start_addr = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_length", 32'(length), 32'd0);
    chk("mid_rst_last", 32'(last_addr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(done), 32'd0);
    end

    // Pointer bits above the address field are ignored.
    write_word(4'd3, 32'hFFFF_FFF7);
    run_walk("upper_bits", 4'd3, -1, 1'b0, 4'd0, 32'd0);

    // Random lists, occasionally loading a word in the same cycle as start.
    for (int it = 0; it < 30; it++) begin
      for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
        d = $urandom();
        if ($urandom_range(0, 2) == 0) d[AW-1:0] = '0;
        write_word(AW'($urandom_range(0, 15)), d);
      end
      wd = $urandom();
      run_walk("rand", AW'($urandom_range(0, 15)), -1, ($urandom_range(0, 3) == 0),
               AW'($urandom_range(0, 15)), wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
